// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the data-memory bus.
// Stores to TXDATA queue bytes in a small FIFO; a four-state FSM shifts them out LSB first.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0400,
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    output logic        TxSerial,
    output logic        TxBusy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_e;

    txState_e         state, stateNext;
    logic [31:0]      addrOffset;
    logic [1:0]       wordSel;
    logic             pushReq, pushOk, popFifo, baudTick;
    logic             statusRead, baudWrite;
    logic             fifoEmpty, fifoFull, overrun;
    logic [CNT_W-1:0] fifoCount;
    logic [PTR_W-1:0] wrPtr, rdPtr;
    logic [7:0]       fifoMem [FIFO_DEPTH];
    logic [7:0]       shiftReg;
    logic [15:0]      baudDiv, divShadow, baudCnt;
    logic [2:0]       bitIdx;
    logic [3:0]       countField;
    logic [15:0]      unusedWriteBits;

    assign unusedWriteBits = WriteData[31:16];

    // Address decode: three aligned words starting at BASE_ADDR
    assign addrOffset = Address - BASE_ADDR;
    assign Hit        = (Address >= BASE_ADDR) && (addrOffset <= 32'd8) && (Address[1:0] == 2'b00);
    assign wordSel    = addrOffset[3:2];

    assign pushReq    = MemWrite && Hit && (wordSel == 2'd0);
    assign baudWrite  = MemWrite && Hit && (wordSel == 2'd2);
    assign statusRead = MemRead  && Hit && (wordSel == 2'd1);
    assign pushOk     = pushReq && ((fifoCount < DEPTH_C) || popFifo);

    assign fifoEmpty  = (fifoCount == '0);
    assign fifoFull   = (fifoCount == DEPTH_C);
    assign countField = 4'(fifoCount);
    assign TxBusy     = (state != IDLE) || !fifoEmpty;

    always_comb begin
        ReadData = 32'd0;
        if (Hit && MemRead) begin
            case (wordSel)
                2'd1:    ReadData = {24'd0, countField, overrun, fifoEmpty, fifoFull, TxBusy};
                2'd2:    ReadData = {16'd0, baudDiv};
                default: ReadData = 32'd0;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        popFifo   = 1'b0;
        baudTick  = (baudCnt == divShadow - 16'd1);
        case (state)
            IDLE: begin
                if (!fifoEmpty) begin
                    popFifo   = 1'b1;
                    stateNext = START;
                end
            end
            START: if (baudTick) stateNext = DATA;
            DATA:  if (baudTick && bitIdx == 3'd7) stateNext = STOP;
            STOP:  if (baudTick) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        case (state)
            START:   TxSerial = 1'b0;
            DATA:    TxSerial = shiftReg[bitIdx];
            default: TxSerial = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifoCount <= '0;
            wrPtr     <= '0;
            rdPtr     <= '0;
            overrun   <= 1'b0;
            baudDiv   <= DEFAULT_DIV;
            baudCnt   <= 16'd0;
            bitIdx    <= 3'd0;
        end else begin
            if (pushOk)  wrPtr <= wrPtr + 1'b1;
            if (popFifo) rdPtr <= rdPtr + 1'b1;
            case ({pushOk, popFifo})
                2'b10:   fifoCount <= fifoCount + 1'b1;
                2'b01:   fifoCount <= fifoCount - 1'b1;
                default: fifoCount <= fifoCount;
            endcase

            // A rejected push in the same cycle as a STATUS read keeps the flag set
            if (pushReq && !pushOk) overrun <= 1'b1;
            else if (statusRead)    overrun <= 1'b0;

            if (baudWrite) baudDiv <= (WriteData[15:0] == 16'd0) ? 16'd1 : WriteData[15:0];

            if (popFifo || state == IDLE) baudCnt <= 16'd0;
            else if (baudTick)            baudCnt <= 16'd0;
            else                          baudCnt <= baudCnt + 16'd1;

            if (state == START && baudTick)     bitIdx <= 3'd0;
            else if (state == DATA && baudTick) bitIdx <= bitIdx + 3'd1;
        end
    end

    // Datapath storage carries no reset; it is only observed once control says it is valid
    always_ff @(posedge clk) begin
        if (pushOk) fifoMem[wrPtr] <= WriteData[7:0];
        if (popFifo) begin
            shiftReg  <= fifoMem[rdPtr];
            divShadow <= baudDiv;
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register map, frame timing, FIFO overrun, divider and reset behaviour.
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE   = 32'h1001_0400;
    localparam logic [31:0] A_TX   = BASE;
    localparam logic [31:0] A_STAT = BASE + 32'd4;
    localparam logic [31:0] A_BAUD = BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [31:0] ReadData;
    logic        Hit, TxSerial, TxBusy;

    int vecCount  = 0;
    int missCount = 0;

    mmio_uart_tx dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .ReadData(ReadData),
        .Hit(Hit), .TxSerial(TxSerial), .TxBusy(TxBusy)
    );

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCount++;
        if (obs !== exp) begin
            missCount++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        Address = addr; WriteData = data; MemWrite = 1'b1;
        @(posedge clk);
        #1 MemWrite = 1'b0;
    endtask

    task automatic busRead(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        Address = addr; MemRead = 1'b1;
        #1 data = ReadData;
        @(posedge clk);
        #1 MemRead = 1'b0;
    endtask

    // Called right after the store edge; the frame begins on the following edge
    task automatic checkFrame(input logic [7:0] b, input int div, input string tag);
        logic expBit;
        int   k;
        @(posedge clk);
        for (int i = 0; i < 10 * div; i++) begin
            @(negedge clk);
            k = i / div;
            expBit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            checkVal(tag, 32'(TxSerial), 32'(expBit));
        end
    endtask

    task automatic rxByte(input int div, output logic [7:0] b, output logic stopBit);
        int waitCnt;
        waitCnt = 0;
        b = 8'd0;
        stopBit = 1'b0;
        @(negedge clk);
        while (TxSerial !== 1'b0 && waitCnt < 500) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 500) begin
            checkVal("rx_start_timeout", 32'(waitCnt), 32'd0);
            return;
        end
        for (int k = 0; k < 8; k++) begin
            repeat (div) @(negedge clk);
            b[k] = TxSerial;
        end
        repeat (div) @(negedge clk);
        stopBit = TxSerial;
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while (TxBusy !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkVal(tag, 32'(TxBusy), 32'd0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [7:0]  rb;
        logic        sb;
        logic [7:0]  txBytes [5];
        int          lowCount;

        txBytes[0] = 8'h11; txBytes[1] = 8'h22; txBytes[2] = 8'h33;
        txBytes[3] = 8'h44; txBytes[4] = 8'h55;

        // Test 1: reset state and decode
        repeat (3) @(negedge clk);
        checkVal("rst_line", 32'(TxSerial), 32'd1);
        checkVal("rst_busy", 32'(TxBusy), 32'd0);
        reset = 1'b1;
        busRead(A_STAT, rd);  checkVal("rst_status", rd, 32'h0000_0004);
        busRead(A_BAUD, rd);  checkVal("rst_baud", rd, 32'd868);
        busRead(A_TX, rd);    checkVal("txdata_read", rd, 32'd0);
        @(negedge clk);
        Address = A_BAUD; #1;
        checkVal("hit_baud", 32'(Hit), 32'd1);
        checkVal("rd_no_memread", ReadData, 32'd0);
        Address = BASE + 32'd1;  #1 checkVal("hit_misaligned", 32'(Hit), 32'd0);
        Address = BASE + 32'd12; #1 checkVal("hit_above", 32'(Hit), 32'd0);
        Address = BASE - 32'd4;  #1 checkVal("hit_below", 32'(Hit), 32'd0);
        busWrite(BASE + 32'd2, 32'h77);
        busRead(A_STAT, rd);  checkVal("misaligned_no_push", rd, 32'h0000_0004);

        // Test 2: one byte at div 4
        busWrite(A_BAUD, 32'd4);
        busRead(A_BAUD, rd);  checkVal("baud4", rd, 32'd4);
        busWrite(A_TX, 32'hA5);
        checkFrame(8'hA5, 4, "t2_frame");
        @(negedge clk);
        checkVal("t2_idle_line", 32'(TxSerial), 32'd1);
        checkVal("t2_busy_drop", 32'(TxBusy), 32'd0);

        // Test 3: burst fill, overrun and its clear-on-read
        busWrite(A_BAUD, 32'd2);
        fork
            begin
                for (int i = 0; i < 5; i++) busWrite(A_TX, 32'(txBytes[i]));
                busWrite(A_TX, 32'h66);
                busRead(A_STAT, rd);  checkVal("t3_status_ovr", rd, 32'h0000_004B);
                busRead(A_STAT, rd);  checkVal("t3_status_clr", rd, 32'h0000_0043);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    rxByte(2, rb, sb);
                    checkVal("t3_rx_byte", 32'(rb), 32'(txBytes[i]));
                    checkVal("t3_rx_stop", 32'(sb), 32'd1);
                end
            end
        join
        waitIdle("t3_drain");
        busRead(A_STAT, rd);  checkVal("t3_status_end", rd, 32'h0000_0004);

        // Test 4: zero divider is stored as one
        busWrite(A_BAUD, 32'd0);
        busRead(A_BAUD, rd);  checkVal("baud_zero", rd, 32'd1);
        busWrite(A_TX, 32'h01);
        checkFrame(8'h01, 1, "t4_frame");
        @(negedge clk);
        checkVal("t4_busy_drop", 32'(TxBusy), 32'd0);

        // Test 5: divider change mid-frame takes effect on the next frame
        busWrite(A_BAUD, 32'd8);
        busWrite(A_TX, 32'h55);
        fork
            begin
                checkFrame(8'h55, 8, "t5_frame1");
                @(negedge clk);
                checkVal("t5_gap_line", 32'(TxSerial), 32'd1);
                checkVal("t5_gap_busy", 32'(TxBusy), 32'd1);
                checkFrame(8'h3C, 3, "t5_frame2");
                @(negedge clk);
                checkVal("t5_busy_drop", 32'(TxBusy), 32'd0);
            end
            begin
                repeat (30) @(posedge clk);
                busWrite(A_BAUD, 32'd3);
                busWrite(A_TX, 32'h3C);
            end
        join
        busRead(A_BAUD, rd);  checkVal("t5_baud3", rd, 32'd3);

        // Test 6: reset during data bit 4
        busWrite(A_TX, 32'h0F);
        busWrite(A_TX, 32'hAA);
        repeat (16) @(posedge clk);
        #2 checkVal("t6_bit4_low", 32'(TxSerial), 32'd0);
        reset = 1'b0;
        #1;
        checkVal("t6_line_high", 32'(TxSerial), 32'd1);
        checkVal("t6_busy_low", 32'(TxBusy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        busRead(A_STAT, rd);  checkVal("t6_status", rd, 32'h0000_0004);
        busRead(A_BAUD, rd);  checkVal("t6_baud_default", rd, 32'd868);
        lowCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (TxSerial !== 1'b1) lowCount++;
        end
        checkVal("t6_no_toggle", 32'(lowCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
